// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: TX FIFO toward the bus (pndng/D_pop/pop),
// RX FIFO from the bus (push/D_push) with destination filtering and loss counters.
module bus_dev_endpoint #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [pckg_sz-1:0]           tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         pndng,
    output logic [pckg_sz-1:0]           D_pop,
    input  logic                         pop,
    input  logic                         push,
    input  logic [pckg_sz-1:0]           D_push,
    output logic [pckg_sz-1:0]           rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [$clog2(depth+1)-1:0]   tx_count,
    output logic [$clog2(depth+1)-1:0]   rx_count,
    output logic [7:0]                   drop_cnt,
    output logic [7:0]                   misroute_cnt
);

    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned CW = $clog2(depth+1);
    localparam logic [CW-1:0] FULL = CW'(depth);

    logic [pckg_sz-1:0] tx_mem_q [depth];
    logic [pckg_sz-1:0] rx_mem_q [depth];

    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]    drop_q, drop_d, mis_q, mis_d;

    logic       tx_wr, tx_rd, rx_wr, rx_rd;
    logic       hit, rx_drop, rx_mis;
    logic [7:0] dest;

    always_comb begin
        tx_ready = (tx_cnt_q < FULL);
        pndng    = (tx_cnt_q != '0);
        D_pop    = pndng ? tx_mem_q[tx_rp_q] : '0;
        rx_valid = (rx_cnt_q != '0);
        rx_data  = rx_valid ? rx_mem_q[rx_rp_q] : '0;
        tx_count = tx_cnt_q;
        rx_count = rx_cnt_q;
        drop_cnt = drop_q;
        misroute_cnt = mis_q;
    end

    always_comb begin
        tx_wr = tx_valid & tx_ready;
        tx_rd = pop & pndng;
        tx_wp_d = tx_wr ? tx_wp_q + PW'(1) : tx_wp_q;
        tx_rp_d = tx_rd ? tx_rp_q + PW'(1) : tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_wr && !tx_rd) begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end else if (!tx_wr && tx_rd) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end
    end

    // A host read in the same cycle frees a slot for an incoming packet.
    always_comb begin
        dest    = D_push[pckg_sz-1 -: 8];
        hit     = (dest == id) || (dest == broadcast);
        rx_rd   = rx_ready & rx_valid;
        rx_wr   = push & hit & ((rx_cnt_q < FULL) | rx_rd);
        rx_drop = push & hit & ~rx_wr;
        rx_mis  = push & ~hit;
        rx_wp_d = rx_wr ? rx_wp_q + PW'(1) : rx_wp_q;
        rx_rp_d = rx_rd ? rx_rp_q + PW'(1) : rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_wr && !rx_rd) begin
            rx_cnt_d = rx_cnt_q + CW'(1);
        end else if (!rx_wr && rx_rd) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end
        drop_d = (rx_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        mis_d  = (rx_mis && mis_q != 8'hFF) ? mis_q + 8'd1 : mis_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            drop_q   <= '0;
            mis_q    <= '0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            drop_q   <= drop_d;
            mis_q    <= mis_d;
        end
    end

    // Storage is not reset; reads are masked by the occupancy counts.
    always_ff @(posedge clk) begin
        if (!reset && tx_wr) begin
            tx_mem_q[tx_wp_q] <= tx_data;
        end
        if (!reset && rx_wr) begin
            rx_mem_q[rx_wp_q] <= D_push;
        end
    end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Randomized and directed bench for bus_dev_endpoint (id=2, depth=8)
// against a queue-based reference model.
module tb_bus_dev_endpoint;

    logic        clk = 0;
    logic        reset;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  tx_count;
    logic [3:0]  rx_count;
    logic [7:0]  drop_cnt;
    logic [7:0]  misroute_cnt;

    int total = 0;
    int bad = 0;

    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    int drops;
    int mis;

    bus_dev_endpoint #(
        .pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count),
        .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        tx_valid = 0; tx_data = '0; pop = 0;
        push = 0; D_push = '0; rx_ready = 0;
    endtask

    // Apply one cycle of stimulus and advance the reference model.
    task automatic cycle(input logic tv, input logic [15:0] td, input logic p,
                         input logic ps, input logic [15:0] pd, input logic rr);
        bit tx_acc, pop_do, rd_do, cand, rx_acc;
        tx_valid = tv; tx_data = td; pop = p;
        push = ps; D_push = pd; rx_ready = rr;
        tx_acc = tv && (txq.size() < 8);
        pop_do = p && (txq.size() > 0);
        rd_do  = rr && (rxq.size() > 0);
        cand   = ps && (pd[15:8] == 8'h02 || pd[15:8] == 8'hFF);
        rx_acc = cand && ((rxq.size() < 8) || rd_do);
        if (pop_do) void'(txq.pop_front());
        if (tx_acc) txq.push_back(td);
        if (rd_do) void'(rxq.pop_front());
        if (rx_acc) rxq.push_back(pd);
        if (cand && !rx_acc && drops < 255) drops++;
        if (ps && !cand && mis < 255) mis++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic do_reset(input logic p, input logic ps);
        idle_inputs();
        reset = 1; pop = p; push = ps; D_push = 16'h0233;
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        txq.delete(); rxq.delete(); drops = 0; mis = 0;
    endtask

    task automatic test_reset();
        do_reset(0, 0);
        total++;
        if ({pndng, rx_valid, tx_ready} !== 3'b001) begin
            bad++; $display("FAIL reset_flags got=%b want=001", {pndng, rx_valid, tx_ready});
        end
        total++;
        if (D_pop !== 16'h0 || rx_data !== 16'h0) begin
            bad++; $display("FAIL reset_data got D_pop=%h rx_data=%h want 0", D_pop, rx_data);
        end
        total++;
        if (tx_count !== 0 || rx_count !== 0 || drop_cnt !== 0 || misroute_cnt !== 0) begin
            bad++; $display("FAIL reset_counts got %0d %0d %0d %0d want 0", tx_count, rx_count, drop_cnt, misroute_cnt);
        end
    endtask

    task automatic test_tx_basic();
        cycle(1, 16'h0312, 0, 0, 0, 0);
        total++;
        if (pndng !== 1 || D_pop !== 16'h0312) begin
            bad++; $display("FAIL tx_first got pndng=%b D_pop=%h want 1 0312", pndng, D_pop);
        end
        cycle(1, 16'h0145, 0, 0, 0, 0);
        total++;
        if (D_pop !== 16'h0312 || tx_count !== 2) begin
            bad++; $display("FAIL tx_second got D_pop=%h cnt=%0d want 0312 2", D_pop, tx_count);
        end
        cycle(0, 0, 1, 0, 0, 0);
        total++;
        if (D_pop !== 16'h0145) begin
            bad++; $display("FAIL tx_pop1 got %h want 0145", D_pop);
        end
        cycle(0, 0, 1, 0, 0, 0);
        total++;
        if (pndng !== 0 || D_pop !== 16'h0) begin
            bad++; $display("FAIL tx_pop2 got pndng=%b D_pop=%h want 0 0000", pndng, D_pop);
        end
        cycle(0, 0, 1, 0, 0, 0);
        total++;
        if (tx_count !== 0 || pndng !== 0) begin
            bad++; $display("FAIL tx_underflow got cnt=%0d pndng=%b want 0 0", tx_count, pndng);
        end
    endtask

    task automatic test_tx_full();
        logic [15:0] exp [8];
        for (int i = 0; i < 8; i++) begin
            exp[i] = 16'($urandom);
            cycle(1, exp[i], 0, 0, 0, 0);
        end
        total++;
        if (tx_ready !== 0 || tx_count !== 8) begin
            bad++; $display("FAIL tx_full got ready=%b cnt=%0d want 0 8", tx_ready, tx_count);
        end
        cycle(1, 16'hDEAD, 0, 0, 0, 0);
        total++;
        if (tx_count !== 8 || D_pop !== exp[0]) begin
            bad++; $display("FAIL tx_full_write got cnt=%0d head=%h want 8 %h", tx_count, D_pop, exp[0]);
        end
        cycle(1, 16'hBEEF, 1, 0, 0, 0);
        total++;
        if (tx_count !== 7) begin
            bad++; $display("FAIL tx_full_popwr got cnt=%0d want 7", tx_count);
        end
        for (int i = 1; i < 8; i++) begin
            total++;
            if (D_pop !== exp[i]) begin
                bad++; $display("FAIL tx_order[%0d] got %h want %h", i, D_pop, exp[i]);
            end
            cycle(0, 0, 1, 0, 0, 0);
        end
        total++;
        if (pndng !== 0 || tx_count !== 0) begin
            bad++; $display("FAIL tx_drained got pndng=%b cnt=%0d want 0 0", pndng, tx_count);
        end
    endtask

    task automatic test_rx_addr();
        cycle(0, 0, 0, 1, 16'h0255, 0);
        total++;
        if (rx_valid !== 1 || rx_data !== 16'h0255) begin
            bad++; $display("FAIL rx_own got valid=%b data=%h want 1 0255", rx_valid, rx_data);
        end
        cycle(0, 0, 0, 1, 16'hFF11, 0);
        total++;
        if (rx_count !== 2) begin
            bad++; $display("FAIL rx_bcast got cnt=%0d want 2", rx_count);
        end
        cycle(0, 0, 0, 1, 16'h0799, 0);
        total++;
        if (misroute_cnt !== 1 || rx_count !== 2 || drop_cnt !== 0) begin
            bad++; $display("FAIL rx_misroute got mis=%0d cnt=%0d drop=%0d want 1 2 0", misroute_cnt, rx_count, drop_cnt);
        end
        cycle(0, 0, 0, 0, 0, 1);
        total++;
        if (rx_data !== 16'hFF11) begin
            bad++; $display("FAIL rx_read got %h want ff11", rx_data);
        end
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        total++;
        if (rx_valid !== 0 || rx_data !== 16'h0 || rx_count !== 0) begin
            bad++; $display("FAIL rx_empty got valid=%b data=%h cnt=%0d want 0 0 0", rx_valid, rx_data, rx_count);
        end
    endtask

    task automatic test_rx_overflow();
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 16'h0240 + 16'(i), 0);
        total++;
        if (rx_count !== 8) begin
            bad++; $display("FAIL rx_fill got cnt=%0d want 8", rx_count);
        end
        cycle(0, 0, 0, 1, 16'h0201, 0);
        total++;
        if (drop_cnt !== 1 || rx_count !== 8) begin
            bad++; $display("FAIL rx_drop got drop=%0d cnt=%0d want 1 8", drop_cnt, rx_count);
        end
        cycle(0, 0, 0, 1, 16'h0202, 1);
        total++;
        if (drop_cnt !== 1 || rx_count !== 8 || rx_data !== 16'h0241) begin
            bad++; $display("FAIL rx_full_rdwr got drop=%0d cnt=%0d head=%h want 1 8 0241", drop_cnt, rx_count, rx_data);
        end
        for (int i = 0; i < 300; i++) cycle(0, 0, 0, 1, 16'hFF00 + 16'(i[7:0]), 0);
        total++;
        if (drop_cnt !== 8'd255 || drop_cnt !== 8'(drops)) begin
            bad++; $display("FAIL rx_drop_sat got %0d want 255", drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (rx_data !== rxq[0]) begin
                bad++; $display("FAIL rx_order[%0d] got %h want %h", i, rx_data, rxq[0]);
            end
            cycle(0, 0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 16'h0A00 + 16'(i), 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 16'h0200 + 16'(i), 0);
        cycle(0, 0, 0, 1, 16'h0500, 0);
        total++;
        if (tx_count !== 3 || rx_count !== 5 || misroute_cnt !== 1) begin
            bad++; $display("FAIL mid_pre got tx=%0d rx=%0d mis=%0d want 3 5 1", tx_count, rx_count, misroute_cnt);
        end
        do_reset(1, 1);
        total++;
        if (tx_count !== 0 || rx_count !== 0 || pndng !== 0 || rx_valid !== 0) begin
            bad++; $display("FAIL mid_reset got tx=%0d rx=%0d pndng=%b rxv=%b want 0", tx_count, rx_count, pndng, rx_valid);
        end
        total++;
        if (drop_cnt !== 0 || misroute_cnt !== 0 || tx_ready !== 1) begin
            bad++; $display("FAIL mid_reset_cnt got drop=%0d mis=%0d rdy=%b want 0 0 1", drop_cnt, misroute_cnt, tx_ready);
        end
    endtask

    task automatic test_random();
        logic [15:0] pd, exp_dp, exp_rd;
        logic [7:0]  dst;
        int sel;
        int errs;
        errs = 0;
        do_reset(0, 0);
        for (int n = 0; n < 2000; n++) begin
            sel = int'($urandom_range(0, 3));
            dst = (sel == 0) ? 8'h02 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h02 : 8'($urandom);
            pd = {dst, 8'($urandom)};
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), pd, 1'($urandom_range(0, 2) == 0));
            exp_dp = (txq.size() > 0) ? txq[0] : 16'h0;
            exp_rd = (rxq.size() > 0) ? rxq[0] : 16'h0;
            total++;
            if (D_pop !== exp_dp || pndng !== (txq.size() > 0) || tx_count !== 4'(txq.size())
                || tx_ready !== (txq.size() < 8) || tx_count > 8) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL rand_tx[%0d] got %h/%b/%0d want %h/%0d", n, D_pop, pndng, tx_count, exp_dp, txq.size());
            end
            total++;
            if (rx_data !== exp_rd || rx_valid !== (rxq.size() > 0) || rx_count !== 4'(rxq.size())
                || drop_cnt !== 8'(drops) || misroute_cnt !== 8'(mis) || rx_count > 8) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL rand_rx[%0d] got %h/%0d/%0d/%0d want %h/%0d/%0d/%0d", n, rx_data, rx_count,
                             drop_cnt, misroute_cnt, exp_rd, rxq.size(), drops, mis);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_tx_basic();
        test_tx_full();
        test_rx_addr();
        test_rx_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
